// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic computing stream blocks.
// Default geometry matches the arch sweep baseline: 5-bit operands, two streams.
package dsc_pkg;
  localparam int DSC_W = 5;
  localparam int DSC_N = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} dsc_state_e;

  typedef logic [DSC_N-1:0][DSC_W-1:0] dsc_ops_t;

  // Full run length: every combination of operand digit positions once.
  function automatic longint unsigned dsc_len(input int w, input int n);
    return 64'd1 << (w * n);
  endfunction
endpackage

// File: rtl/dsc_unary_cmp.sv
// Unary stream bit: high while the current digit is below the operand.
// Shared with the by-N stream multipliers.
module dsc_unary_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] digit,
  input  logic [W-1:0] op,
  output logic         lt
);
  assign lt = (digit < op);
endmodule

// File: rtl/dsc_stream_gen.sv
// Clock-division DSC bitstream generator: one W-bit digit of a shared W*N-bit
// counter per operand, so stream i advances once every 2^(W*i) beats.
module dsc_stream_gen
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = DSC_W,
  parameter int NUM_INPUTS = DSC_N
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  start,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] bin_data_in,
  output logic                                  ready,
  output logic [NUM_INPUTS-1:0]                 stream_out,
  output logic                                  stream_valid,
  output logic                                  stream_last,
  output logic                                  done
);
  localparam int CNT_W = DATA_WIDTH * NUM_INPUTS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(dsc_len(DATA_WIDTH, NUM_INPUTS) - 64'd1);

  dsc_state_e                            state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] op_q, op_d;
  logic                                  ready_q, ready_d;
  logic [NUM_INPUTS-1:0]                 out_q, out_d;
  logic                                  valid_q, valid_d;
  logic                                  last_q, last_d;
  logic                                  done_q, done_d;
  logic [NUM_INPUTS-1:0]                 lt;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cmp
    dsc_unary_cmp #(.W(DATA_WIDTH)) u_cmp (
      .digit (cnt_q[DATA_WIDTH*i +: DATA_WIDTH]),
      .op    (op_q[i]),
      .lt    (lt[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ready_d = 1'b0;
    out_d   = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // ready_q gates accept so the first cycle out of reset cannot start a run.
        if (ready_q && start) begin
          op_d    = bin_data_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (en) begin
          out_d   = lt;
          valid_d = 1'b1;
          last_d  = (cnt_q == CNT_LAST);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ready_q <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign ready        = ready_q;
  assign stream_out   = out_q;
  assign stream_valid = valid_q;
  assign stream_last  = last_q;
  assign done         = done_q;
endmodule

// File: tb/tb_dsc_stream_gen.sv
// Randomized bench for dsc_stream_gen: a beat-index reference model checked
// every cycle, plus literal per-run ones counts and latency checks.
module tb_dsc_stream_gen;
  import dsc_pkg::*;
  localparam int W = 5;
  localparam int N = 2;
  localparam int L = 1 << (W * N);

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, start = 1'b0;
  dsc_ops_t bin = '0;
  logic ready, stream_valid, stream_last, done;
  logic [N-1:0] stream_out;

  dsc_stream_gen #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .bin_data_in(bin),
    .ready(ready), .stream_out(stream_out), .stream_valid(stream_valid),
    .stream_last(stream_last), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_print = 0;

  task automatic chk(input string nm, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  // Reference model: a run is L beats indexed k; beat k drives stream i high
  // when the i-th W-bit digit of k is below op[i].
  logic e_ready = 0, e_valid = 0, e_last = 0, e_done = 0;
  logic [N-1:0] e_out = '0;
  bit m_busy = 0, m_done_nx = 0, prev_ready;
  int m_k = 0;
  dsc_ops_t m_op;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      {e_ready, e_valid, e_last, e_done} = '0;
      e_out = '0; m_busy = 0; m_done_nx = 0; m_k = 0;
    end else begin
      prev_ready = e_ready;
      {e_ready, e_valid, e_last, e_done} = '0;
      e_out = '0;
      if (m_done_nx) begin
        e_done = 1; m_done_nx = 0;
      end else if (m_busy) begin
        if (en) begin
          e_valid = 1;
          for (int i = 0; i < N; i++)
            e_out[i] = (((m_k >> (W * i)) & ((1 << W) - 1)) < int'(m_op[i]));
          e_last = (m_k == L - 1);
          if (e_last) begin m_busy = 0; m_done_nx = 1; end
          m_k++;
        end
      end else if (prev_ready && start) begin
        m_busy = 1; m_op = bin; m_k = 0;
      end else begin
        e_ready = 1;
      end
    end
  end

  // Compare process plus per-run statistics.
  int beats = 0, ones0 = 0, ones1 = 0, ones_and = 0;
  bit saw_last = 0;
  initial forever begin
    @(negedge clk);
    n_chk++;
    if ({ready, stream_valid, stream_last, done, stream_out} ==
        {e_ready, e_valid, e_last, e_done, e_out}) n_pass++;
    else if (n_print++ < 20)
      $display("FAIL cycle @%0t: got rdy%0d v%0d l%0d d%0d o%b want rdy%0d v%0d l%0d d%0d o%b",
               $time, ready, stream_valid, stream_last, done, stream_out,
               e_ready, e_valid, e_last, e_done, e_out);
    if (stream_last && done) begin n_chk++; $display("FAIL last_done_overlap @%0t: got 1 want 0", $time); end
    if (done && !saw_last) begin n_chk++; $display("FAIL done_without_last @%0t: got 1 want 0", $time); end
    if (rst || ready) begin
      beats = 0; ones0 = 0; ones1 = 0; ones_and = 0; saw_last = 0;
    end else begin
      if (stream_valid) begin
        beats++;
        ones0 += int'(stream_out[0]);
        ones1 += int'(stream_out[1]);
        ones_and += int'(&stream_out);
      end
      if (stream_last) saw_last = 1;
      if (done) saw_last = 0;
    end
  end

  task automatic wait_ready(input string nm);
    int to = 0;
    while (!ready && to < 100) begin @(negedge clk); to++; end
    if (!ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic run(input string nm, input int a0, input int a1,
                     input int x0, input int x1, input int xa,
                     input bit rnd, input bit hold);
    int n = 0, stalls = 0;
    bit got_done = 0;
    wait_ready(nm);
    bin[0] = W'(a0); bin[1] = W'(a1); start = 1; en = 1;
    @(negedge clk);
    if (!hold) start = 0;
    while (n < 5000) begin
      if (rnd) en = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (hold && n == 300) begin bin[0] = 5'd30; bin[1] = 5'd29; end
      if (done) begin got_done = 1; break; end
      if (!stream_valid) stalls++;
    end
    en = 1;
    chk({nm, "_done_seen"}, got_done, 1);
    chk({nm, "_latency"}, n, L + 1 + stalls);
    chk({nm, "_beats"}, beats, L);
    chk({nm, "_ones0"}, ones0, x0);
    chk({nm, "_ones1"}, ones1, x1);
    chk({nm, "_ones_and"}, ones_and, xa);
    chk({nm, "_ready_on_done"}, ready, 0);
    @(negedge clk);
    chk({nm, "_ready_after_done"}, ready, 1);
  endtask

  initial begin
    int to;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ready, stream_valid, stream_last, done, stream_out}, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", ready, 1);

    run("op3_5",    3,  5,  96, 160,  15, 0, 0);
    run("op31_31", 31, 31, 992, 992, 961, 0, 0);
    run("op0_17",   0, 17,   0, 544,   0, 0, 0);
    run("stall7_9", 7,  9, 224, 288,  63, 1, 0);
    run("hold2_3",  2,  3,  64,  96,   6, 0, 1);
    run("hold30_29", 30, 29, 960, 928, 870, 0, 0);

    // Asynchronous reset mid-run at beat 500.
    wait_ready("rst_run");
    bin[0] = 5'd11; bin[1] = 5'd13; start = 1;
    @(negedge clk);
    start = 0;
    to = 0;
    while (beats < 500 && to < 2000) begin @(negedge clk); to++; end
    chk("rst_reach_beat500", beats, 500);
    #2 rst = 1;
    #1 chk("rst_async_zero", {ready, stream_valid, stream_last, done, stream_out}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    run("after_rst", 4, 6, 128, 192, 24, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
